// File: rtl/rx_tlp_sender_pkg.sv
// Shared constants, state encodings and helpers for the RX TLP sender.
package rx_tlp_sender_pkg;

    // Ring buffer address width is BF+1 bits.
    localparam int BF = 4;

    // MemWr64 with data: 4DW header, fmt=11, type=00000.
    localparam logic [1:0] TLP_FMT_4DW_DATA = 2'b11;
    localparam logic [4:0] TLP_TYPE_MEM     = 5'b00000;
    localparam logic [3:0] TLP_BE_ALL       = 4'hF;

    // The first 'h10 qwords (128 bytes) of every page hold the page header.
    localparam logic [18:0] PAGE_HDR_OFFSET = 19'h10;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_PG,
        HDR0,
        HDR1,
        DATA,
        PH_HDR0,
        PH_HDR1,
        PH_DATA,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        REQ_TRIGGER,
        REQ_LAST,
        REQ_CHANGE
    } req_t;

    // Swapping the two DWs and reversing bytes inside each DW is the same
    // as reversing all eight bytes of the qword.
    function automatic logic [63:0] swap_qword(input logic [63:0] q);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = q[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/rx_tlp_hdr_build.sv
// Combinational builder for the two header beats of a 4DW MemWr64 TLP.
module rx_tlp_hdr_build
    import rx_tlp_sender_pkg::*;
(
    input  logic [9:0]  length,
    input  logic [15:0] requester_id,
    input  logic [63:0] address,
    output logic [63:0] hdr_beat0,
    output logic [63:0] hdr_beat1
);

    logic [31:0] dw0;
    logic [31:0] dw1;

    // Assemble DW0/DW1 (TC, attr, tag all zero; both byte enables full) and the address beat.
    always_comb begin
        dw0 = {1'b0, TLP_FMT_4DW_DATA, TLP_TYPE_MEM, 1'b0, 3'b000, 4'b0000,
               1'b0, 1'b0, 2'b00, 2'b00, length};
        dw1 = {requester_id, 8'h00, TLP_BE_ALL, TLP_BE_ALL};
        hdr_beat0 = {dw0, dw1};
        hdr_beat1 = {address[63:32], address[31:0]};
    end

endmodule

// File: rtl/rx_tlp_sender.sv
// Streams ring-buffer data into host huge pages as MemWr64 TLPs and closes
// pages with a page-header TLP holding the number of data qwords written.
module rx_tlp_sender
    import rx_tlp_sender_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          trigger_tlp,
    output logic          trigger_tlp_ack,
    input  logic          send_last_tlp,
    input  logic          change_huge_page,
    output logic          change_huge_page_ack,
    input  logic [4:0]    qwords_to_send,
    output logic [BF:0]   rd_addr,
    input  logic [63:0]   rd_data,
    input  logic [63:0]   huge_page_addr_1,
    input  logic [63:0]   huge_page_addr_2,
    input  logic          huge_page_status_1,
    input  logic          huge_page_status_2,
    output logic          huge_page_unlock_1,
    output logic          huge_page_unlock_2,
    input  logic [15:0]   cfg_completer_id,
    output logic [63:0]   trn_td,
    output logic [7:0]    trn_trem_n,
    output logic          trn_tsof_n,
    output logic          trn_teof_n,
    output logic          trn_tsrc_rdy_n,
    input  logic          trn_tdst_rdy_n,
    input  logic [3:0]    trn_tbuf_av
);

    state_t        state;
    state_t        state_next;
    req_t          req_kind;
    logic [4:0]    qwords_q;
    logic [4:0]    data_cnt;
    logic [BF:0]   rd_ptr;
    logic [18:0]   page_offset;
    logic          cur_page;

    logic          data_last;
    logic          adv_ptr;
    logic          in_page_hdr;
    logic          page_ready;
    logic [63:0]   page_base;
    logic [63:0]   tlp_addr;
    logic [9:0]    tlp_length;
    logic [63:0]   hdr_beat0;
    logic [63:0]   hdr_beat1;
    logic          unused_tbuf;

    assign unused_tbuf = ^{trn_tbuf_av[3:2], trn_tbuf_av[0]};
    assign trn_trem_n  = 8'h00;

    // Select the current page and form the address/length fed to the header builder.
    always_comb begin
        page_base   = cur_page ? huge_page_addr_2 : huge_page_addr_1;
        page_ready  = cur_page ? huge_page_status_2 : huge_page_status_1;
        in_page_hdr = (state == PH_HDR0) || (state == PH_HDR1);
        tlp_length  = in_page_hdr ? 10'd2 : {4'b0000, qwords_q, 1'b0};
        tlp_addr    = in_page_hdr ? page_base
                                  : page_base + {42'b0, page_offset, 3'b000};
        data_last   = (data_cnt == qwords_q - 5'd1);
    end

    rx_tlp_hdr_build u_hdr_build (
        .length       (tlp_length),
        .requester_id (cfg_completer_id),
        .address      (tlp_addr),
        .hdr_beat0    (hdr_beat0),
        .hdr_beat1    (hdr_beat1)
    );

    // Read address looks one entry ahead on an accepted data beat so the
    // registered rd_data lines up with the next beat; it holds during stalls.
    assign rd_addr = adv_ptr ? rd_ptr + 1'b1 : rd_ptr;

    // Next-state logic and all TRN/handshake outputs.
    always_comb begin
        state_next           = state;
        trn_td               = 64'h0;
        trn_tsof_n           = 1'b1;
        trn_teof_n           = 1'b1;
        trn_tsrc_rdy_n       = 1'b1;
        trigger_tlp_ack      = 1'b0;
        change_huge_page_ack = 1'b0;
        huge_page_unlock_1   = 1'b0;
        huge_page_unlock_2   = 1'b0;
        adv_ptr              = 1'b0;
        unique case (state)
            IDLE: begin
                if (change_huge_page || send_last_tlp || trigger_tlp) begin
                    state_next = WAIT_PG;
                end
            end
            WAIT_PG: begin
                if (page_ready && trn_tbuf_av[1]) begin
                    state_next = (req_kind == REQ_CHANGE) ? PH_HDR0 : HDR0;
                end
            end
            HDR0, PH_HDR0: begin
                trn_tsrc_rdy_n = 1'b0;
                trn_tsof_n     = 1'b0;
                trn_td         = hdr_beat0;
                if (!trn_tdst_rdy_n) begin
                    state_next = (state == HDR0) ? HDR1 : PH_HDR1;
                end
            end
            HDR1, PH_HDR1: begin
                trn_tsrc_rdy_n = 1'b0;
                trn_td         = hdr_beat1;
                if (!trn_tdst_rdy_n) begin
                    state_next = (state == HDR1) ? DATA : PH_DATA;
                end
            end
            DATA: begin
                trn_tsrc_rdy_n = 1'b0;
                trn_teof_n     = ~data_last;
                trn_td         = swap_qword(rd_data);
                if (!trn_tdst_rdy_n) begin
                    adv_ptr = 1'b1;
                    if (data_last) begin
                        state_next = (req_kind == REQ_LAST) ? PH_HDR0 : DONE;
                    end
                end
            end
            PH_DATA: begin
                trn_tsrc_rdy_n = 1'b0;
                trn_teof_n     = 1'b0;
                trn_td         = {45'b0, page_offset - PAGE_HDR_OFFSET};
                if (!trn_tdst_rdy_n) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (req_kind == REQ_TRIGGER) begin
                    trigger_tlp_ack = 1'b1;
                end else begin
                    change_huge_page_ack = 1'b1;
                    huge_page_unlock_1   = ~cur_page;
                    huge_page_unlock_2   = cur_page;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the accepted request kind and its payload size.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_kind <= REQ_TRIGGER;
            qwords_q <= 5'd0;
        end else if (state == IDLE) begin
            if (change_huge_page) begin
                req_kind <= REQ_CHANGE;
                qwords_q <= qwords_to_send;
            end else if (send_last_tlp) begin
                req_kind <= REQ_LAST;
                qwords_q <= qwords_to_send;
            end else if (trigger_tlp) begin
                req_kind <= REQ_TRIGGER;
                qwords_q <= qwords_to_send;
            end
        end
    end

    // Ring-buffer pointer and per-TLP data beat counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr   <= '0;
            data_cnt <= 5'd0;
        end else if (state == HDR1) begin
            data_cnt <= 5'd0;
        end else if (adv_ptr) begin
            rd_ptr   <= rd_ptr + 1'b1;
            data_cnt <= data_cnt + 5'd1;
        end
    end

    // Page fill level and current page; a closed page hands over to the other one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            page_offset <= PAGE_HDR_OFFSET;
            cur_page    <= 1'b0;
        end else if (adv_ptr && data_last) begin
            page_offset <= page_offset + {14'b0, qwords_q};
        end else if (state == DONE && req_kind != REQ_TRIGGER) begin
            page_offset <= PAGE_HDR_OFFSET;
            cur_page    <= ~cur_page;
        end
    end

endmodule

// File: tb/tb_rx_tlp_sender.sv
// Scoreboard bench for rx_tlp_sender: stimulus pushes expected TRN beats,
// a monitor pops and compares every accepted beat.
module tb_rx_tlp_sender;
    import rx_tlp_sender_pkg::*;

    localparam int RING = 1 << (BF + 1);
    localparam logic [63:0] BASE1 = 64'h0000_0001_0000_0000;
    localparam logic [63:0] BASE2 = 64'h0000_0002_0000_0000;
    localparam logic [15:0] CPL_ID = 16'hABCD;

    logic          clk;
    logic          reset_n;
    logic          trigger_tlp;
    logic          trigger_tlp_ack;
    logic          send_last_tlp;
    logic          change_huge_page;
    logic          change_huge_page_ack;
    logic [4:0]    qwords_to_send;
    logic [BF:0]   rd_addr;
    logic [63:0]   rd_data;
    logic          huge_page_status_1;
    logic          huge_page_status_2;
    logic          huge_page_unlock_1;
    logic          huge_page_unlock_2;
    logic [63:0]   trn_td;
    logic [7:0]    trn_trem_n;
    logic          trn_tsof_n;
    logic          trn_teof_n;
    logic          trn_tsrc_rdy_n;
    logic          trn_tdst_rdy_n;
    logic [3:0]    trn_tbuf_av;

    typedef struct {
        logic [63:0] td;
        logic        sof;
        logic        eof;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    model_ptr = 0;
    int    beat_cnt = 0;
    int    pkt_idx = 0;
    int    trig_ack_cnt = 0;
    int    chp_ack_cnt = 0;
    int    unlock1_cnt = 0;
    int    unlock2_cnt = 0;
    bit    stall_mode = 0;
    bit    wrap_armed = 0;

    rx_tlp_sender dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .trigger_tlp          (trigger_tlp),
        .trigger_tlp_ack      (trigger_tlp_ack),
        .send_last_tlp        (send_last_tlp),
        .change_huge_page     (change_huge_page),
        .change_huge_page_ack (change_huge_page_ack),
        .qwords_to_send       (qwords_to_send),
        .rd_addr              (rd_addr),
        .rd_data              (rd_data),
        .huge_page_addr_1     (BASE1),
        .huge_page_addr_2     (BASE2),
        .huge_page_status_1   (huge_page_status_1),
        .huge_page_status_2   (huge_page_status_2),
        .huge_page_unlock_1   (huge_page_unlock_1),
        .huge_page_unlock_2   (huge_page_unlock_2),
        .cfg_completer_id     (CPL_ID),
        .trn_td               (trn_td),
        .trn_trem_n           (trn_trem_n),
        .trn_tsof_n           (trn_tsof_n),
        .trn_teof_n           (trn_teof_n),
        .trn_tsrc_rdy_n       (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n       (trn_tdst_rdy_n),
        .trn_tbuf_av          (trn_tbuf_av)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Ring buffer contents are a fixed function of the entry index.
    function automatic logic [63:0] mem_val(input int idx);
        return {8'h11, 8'(idx), 8'h22, 8'h33, 8'h44, 8'h55, 8'(idx + 100), 8'h66};
    endfunction

    function automatic logic [63:0] byte_rev(input logic [63:0] x);
        logic [63:0] r;
        r = {<<8{x}};
        return r;
    endfunction

    // One-cycle read latency ring buffer.
    always @(posedge clk) begin
        rd_data <= mem_val(int'(rd_addr));
    end

    // Destination readiness: always ready, or toggling each cycle in stall mode.
    initial begin
        trn_tdst_rdy_n = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            trn_tdst_rdy_n = stall_mode ? ~trn_tdst_rdy_n : 1'b0;
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic push_data_tlp(input int q, input logic [63:0] addr);
        beat_t b;
        b.td  = {32'h6000_0000 | 32'(2 * q), CPL_ID, 16'h00FF};
        b.sof = 1'b1;
        b.eof = 1'b0;
        exp_q.push_back(b);
        b.td  = addr;
        b.sof = 1'b0;
        exp_q.push_back(b);
        for (int i = 0; i < q; i++) begin
            b.td  = byte_rev(mem_val(model_ptr));
            b.eof = (i == q - 1);
            exp_q.push_back(b);
            model_ptr = (model_ptr + 1) % RING;
        end
    endtask

    task automatic push_hdr_tlp(input logic [63:0] base, input logic [63:0] value);
        beat_t b;
        b.td  = {32'h6000_0002, CPL_ID, 16'h00FF};
        b.sof = 1'b1;
        b.eof = 1'b0;
        exp_q.push_back(b);
        b.td  = base;
        b.sof = 1'b0;
        exp_q.push_back(b);
        b.td  = value;
        b.eof = 1'b1;
        exp_q.push_back(b);
    endtask

    // Monitor: compare each accepted beat against the scoreboard and count pulses.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (reset_n && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                beat_cnt++;
                pkt_idx = !trn_tsof_n ? 0 : pkt_idx + 1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_beat: got td=%h expected no beat", trn_td);
                end else begin
                    b = exp_q.pop_front();
                    check_output("beat_td", trn_td, b.td);
                    check_output("beat_flags", {54'b0, ~trn_tsof_n, ~trn_teof_n, trn_trem_n},
                                 {54'b0, b.sof, b.eof, 8'h00});
                end
                if (wrap_armed && pkt_idx == 4) begin
                    check_output("rd_addr_wrap", 64'(rd_addr), 64'd0);
                    wrap_armed = 0;
                end
            end
            if (trigger_tlp_ack)      trig_ack_cnt++;
            if (change_huge_page_ack) chp_ack_cnt++;
            if (huge_page_unlock_1)   unlock1_cnt++;
            if (huge_page_unlock_2)   unlock2_cnt++;
        end
    end

    // Raise a request, hold it until its ack (bounded), then confirm the scoreboard drained.
    task automatic apply_stimulus(input int kind, input int q, input string name);
        bit got;
        got = 0;
        qwords_to_send = 5'(q);
        if (kind == 0)      trigger_tlp = 1'b1;
        else if (kind == 1) send_last_tlp = 1'b1;
        else                change_huge_page = 1'b1;
        for (int cyc = 0; cyc < 1000 && !got; cyc++) begin
            @(posedge clk);
            #1;
            if (kind == 0 ? trigger_tlp_ack : change_huge_page_ack) got = 1;
        end
        trigger_tlp = 1'b0;
        send_last_tlp = 1'b0;
        change_huge_page = 1'b0;
        check_output({name, "_ack_seen"}, 64'(got), 64'd1);
        @(posedge clk);
        #1;
        check_output({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_beats;
        bit hit;
        reset_n = 1'b0;
        trigger_tlp = 1'b0;
        send_last_tlp = 1'b0;
        change_huge_page = 1'b0;
        qwords_to_send = 5'd0;
        huge_page_status_1 = 1'b1;
        huge_page_status_2 = 1'b0;
        trn_tbuf_av = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        check_output("reset_strobes", {61'b0, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n}, 64'd7);
        check_output("reset_td_trem", {trn_td[55:0], trn_trem_n}, 64'd0);
        check_output("reset_rd_addr", 64'(rd_addr), 64'd0);
        check_output("reset_acks", {60'b0, trigger_tlp_ack, change_huge_page_ack,
                                    huge_page_unlock_1, huge_page_unlock_2}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 16-qword TLP into page 1 at base + 0x80
        $display("[TB] single 16-qword TLP");
        start_beats = beat_cnt;
        push_data_tlp(16, 64'h0000_0001_0000_0080);
        apply_stimulus(0, 16, "t1");
        check_output("t1_beats", 64'(beat_cnt - start_beats), 64'd18);
        check_output("t1_trig_acks", 64'(trig_ack_cnt), 64'd1);

        // Same size with destination stalling every other cycle
        $display("[TB] 16-qword TLP with backpressure");
        start_beats = beat_cnt;
        stall_mode = 1;
        push_data_tlp(16, 64'h0000_0001_0000_0100);
        apply_stimulus(0, 16, "t2");
        stall_mode = 0;
        check_output("t2_beats", 64'(beat_cnt - start_beats), 64'd18);
        check_output("t2_trig_acks", 64'(trig_ack_cnt), 64'd2);

        // Final 5-qword TLP then page header (16+16+5 = 37)
        $display("[TB] send_last_tlp closes page 1");
        push_data_tlp(5, 64'h0000_0001_0000_0180);
        push_hdr_tlp(BASE1, 64'd37);
        apply_stimulus(1, 5, "t3");
        check_output("t3_chp_acks", 64'(chp_ack_cnt), 64'd1);
        check_output("t3_unlock1", 64'(unlock1_cnt), 64'd1);
        check_output("t3_unlock2", 64'(unlock2_cnt), 64'd0);
        check_output("t3_trig_acks", 64'(trig_ack_cnt), 64'd2);

        // Close page 2 while it is not yet writable: must wait silently
        $display("[TB] change_huge_page waits for page 2 status");
        start_beats = beat_cnt;
        qwords_to_send = 5'd1;
        change_huge_page = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_output("t4_no_beats", 64'(beat_cnt - start_beats), 64'd0);
        check_output("t4_no_ack", 64'(chp_ack_cnt), 64'd1);
        check_output("t4_src_idle", 64'(trn_tsrc_rdy_n), 64'd1);
        push_hdr_tlp(BASE2, 64'd0);
        huge_page_status_2 = 1'b1;
        apply_stimulus(2, 1, "t4");
        check_output("t4_chp_acks", 64'(chp_ack_cnt), 64'd2);
        check_output("t4_unlock2", 64'(unlock2_cnt), 64'd1);
        check_output("t4_unlock1", 64'(unlock1_cnt), 64'd1);

        // Bring rd_ptr to RING-3, then an 8-qword TLP crosses the wrap
        $display("[TB] ring pointer wrap");
        push_data_tlp(16, 64'h0000_0001_0000_0080);
        apply_stimulus(0, 16, "t5a");
        push_data_tlp(8, 64'h0000_0001_0000_0100);
        apply_stimulus(0, 8, "t5b");
        check_output("t5_model_ptr", 64'(model_ptr), 64'(RING - 3));
        wrap_armed = 1;
        push_data_tlp(8, 64'h0000_0001_0000_0140);
        apply_stimulus(0, 8, "t5c");
        check_output("t5_wrap_checked", 64'(wrap_armed), 64'd0);

        // Reset during data beat 4 abandons the packet
        $display("[TB] reset mid-packet");
        start_beats = beat_cnt;
        hit = 0;
        push_data_tlp(16, 64'h0000_0001_0000_0180);
        qwords_to_send = 5'd16;
        trigger_tlp = 1'b1;
        for (int cyc = 0; cyc < 500 && !hit; cyc++) begin
            @(negedge clk);
            #1;
            if (beat_cnt - start_beats >= 6) hit = 1;
        end
        check_output("t6_reached_beat4", 64'(hit), 64'd1);
        reset_n = 1'b0;
        #1;
        check_output("t6_src_rdy_in_reset", 64'(trn_tsrc_rdy_n), 64'd1);
        trigger_tlp = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        repeat (2) @(posedge clk);
        #1;
        check_output("t6_rd_addr_reset", 64'(rd_addr), 64'd0);
        check_output("t6_no_ack", 64'(trig_ack_cnt), 64'd5);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_data_tlp(4, 64'h0000_0001_0000_0080);
        apply_stimulus(0, 4, "t6");
        check_output("t6_trig_acks", 64'(trig_ack_cnt), 64'd6);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_tlp_sender.md
RX_TLP_SENDER -- requirements
Module: rx_tlp_sender

Interface
REQ-001 clk  in  1  core clock; all logic on rising edge.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 trigger_tlp / trigger_tlp_ack  in / out  1 / 1  request and one-cycle ack for one data TLP.
REQ-004 send_last_tlp / change_huge_page  in / in  1 / 1  close page with a final data TLP / close page with no data; both acked by change_huge_page_ack.
REQ-005 change_huge_page_ack  out  1  one-cycle ack for either page-close request.
REQ-006 qwords_to_send  in  5  payload in qwords, 1..16; sampled when the request is accepted.
REQ-007 rd_addr / rd_data  out / in  BF+1 / 64  ring-buffer read port; rd_data reflects the previous cycle's rd_addr.
REQ-008 huge_page_addr_1 / huge_page_addr_2  in  64 / 64  host physical base address of each page.
REQ-009 huge_page_status_1 / huge_page_status_2  in  1 / 1  page is host-released and writable.
REQ-010 huge_page_unlock_1 / huge_page_unlock_2  out  1 / 1  one-cycle pulse; page handed to host.
REQ-011 cfg_completer_id  in  16  requester ID placed in the TLP header.
REQ-012 trn_td / trn_trem_n / trn_tsof_n / trn_teof_n / trn_tsrc_rdy_n  out  64 / 8 / 1 / 1 / 1  TRN TX stream.
REQ-013 trn_tdst_rdy_n / trn_tbuf_av  in  1 / 4  TRN TX backpressure / buffer availability.

Function
REQ-014 Each TLP SHALL be a 4DW MemWr64: fmt=2'b11, type=0, TC/attr=0, tag=0, first/last BE=4'hF, length=2×qwords DW.
REQ-015 Beat 0 SHALL carry {DW0,DW1}, beat 1 {addr[63:32],addr[31:0]}, then one data qword per beat; trn_trem_n=8'h00 on every beat.
REQ-016 Each data qword SHALL be sent with its two DWs swapped and bytes reversed within each DW.
REQ-017 A beat SHALL complete only when trn_tsrc_rdy_n=0 and trn_tdst_rdy_n=0; all outputs, including rd_addr, SHALL hold during a stall.
REQ-018 FSM states: IDLE, WAIT_PG, HDR0, HDR1, DATA, PH_HDR0, PH_HDR1, PH_DATA, DONE.
REQ-019 IDLE SHALL accept requests in priority change_huge_page > send_last_tlp > trigger_tlp and move to WAIT_PG.
REQ-020 WAIT_PG SHALL proceed to HDR0 or PH_HDR0 only when the current page's status=1 and trn_tbuf_av[1]=1.
REQ-021 For a data TLP, address = page base + 8×page_offset; page_offset starts at 'h10 (128-byte header area reserved).
REQ-022 rd_ptr SHALL advance by 1 per data beat and wrap modulo 2^(BF+1); it SHALL start at 0 and never rewind.
REQ-023 page_offset (19 bits) SHALL increase by qwords_to_send after the teof beat; trigger_tlp_ack SHALL pulse in DONE.
REQ-024 For send_last_tlp, the data TLP (REQ-021) SHALL be followed by a page-header TLP.
REQ-025 For change_huge_page, only the page-header TLP SHALL be sent.
REQ-026 Page-header TLP: one qword, written to page base + 0, value {45'b0, page_offset-'h10} (data qwords in page).
REQ-027 After a page-header TLP: pulse change_huge_page_ack and huge_page_unlock of the current page; toggle the current page; set page_offset='h10.
REQ-028 A request SHALL stay asserted until acked; a new request in DONE SHALL wait for IDLE (minimum one idle cycle).

Reset
REQ-029 On reset_n=0 all TRN strobes SHALL be 1 (trn_td=0, trn_trem_n=8'h00).
REQ-030 On reset_n=0 acks and unlocks SHALL be 0; rd_addr=0, rd_ptr=0, page_offset='h10, current page=1, FSM=IDLE.
REQ-031 Reset mid-TLP SHALL abandon the packet without completing it.

Structure
REQ-032 The TLP fmt/type constants, the 'h10 header offset and BF SHALL come from includes.v.
REQ-033 Header assembly SHALL be a combinational sub-module, rx_tlp_hdr_build (inputs: length, requester ID, address).

Verification
REQ-034 Page 1 base 0x1_0000_0000, status=1, trigger with qwords=16 -> 18 beats; DW0=32'h6000_0020; address 0x1_0000_0080; one ack pulse.
REQ-035 Same as REQ-034 with trn_tdst_rdy_n toggling every other cycle -> identical data sequence with no duplicated or skipped qwords.
REQ-036 Two 16-qword TLPs, then send_last_tlp with qwords=5 -> 5-qword TLP at base+0x180; header TLP value 37 at base+0; unlock_1 pulse; page 2 becomes current.
REQ-037 change_huge_page with huge_page_status_2=0 -> stays in WAIT_PG with no TRN activity; set status=1 -> header TLP value 0; ack and unlock_2 pulse.
REQ-038 rd_ptr at 2^(BF+1)-3 plus an 8-qword trigger -> rd_addr wraps to 0 after 3 beats.
REQ-039 Assert reset_n=0 at data beat 4 -> trn_tsrc_rdy_n=1 immediately; after release, next trigger starts at rd_addr 0, offset 'h10.
